// File: rtl/punc_control_if.sv
// Control bundle between the PUnC control unit (master) and its datapath (slave).
// The master reads IR opcode bits and condition codes and drives every datapath strobe/select.
interface punc_control_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       ir_op;
  logic [2:0]       cond;
  logic             ir_ld;
  logic             pc_ld;
  logic [1:0]       pc_sel;
  logic [1:0]       mem_addr_sel;
  logic             mem_w_en;
  logic             tmp_ld;
  logic             rf_w_en;
  logic             rf_w_addr_sel;
  logic [1:0]       rf_w_data_sel;
  logic [1:0]       alu_op;
  logic             cond_ld;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  ir_op, cond,
    output ir_ld, pc_ld, pc_sel, mem_addr_sel, mem_w_en, tmp_ld, rf_w_en,
           rf_w_addr_sel, rf_w_data_sel, alu_op, cond_ld, halted, instr_count
  );

  modport slave (
    output ir_op, cond,
    input  ir_ld, pc_ld, pc_sel, mem_addr_sel, mem_w_en, tmp_ld, rf_w_en,
           rf_w_addr_sel, rf_w_data_sel, alu_op, cond_ld, halted, instr_count
  );
endinterface

// File: rtl/punc_control.sv
// Multi-cycle LC3 control FSM: fetch, decode, execute (plus a second execute cycle
// for LDI/STI), halting on TRAP; also counts retired instructions.
module punc_control #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  punc_control_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, EXEC2, HALT} state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic [3:0]       opcode;
  logic [2:0]       lo_bits;

  assign opcode  = bus.ir_op[6:3];
  assign lo_bits = bus.ir_op[2:0];

  // Everything is gated by rst so no strobe can be seen while reset is held.
  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    bus.ir_ld         = 1'b0;
    bus.pc_ld         = 1'b0;
    bus.pc_sel        = 2'd0;
    bus.mem_addr_sel  = 2'd0;
    bus.mem_w_en      = 1'b0;
    bus.tmp_ld        = 1'b0;
    bus.rf_w_en       = 1'b0;
    bus.rf_w_addr_sel = 1'b0;
    bus.rf_w_data_sel = 2'd0;
    bus.alu_op        = 2'd0;
    bus.cond_ld       = 1'b0;
    bus.halted        = 1'b0;
    if (rst) begin
      case (state_q)
        FETCH: begin
          bus.ir_ld = 1'b1;
          state_d   = DECODE;
        end
        DECODE: begin
          bus.pc_ld = 1'b1;
          state_d   = EXEC;
        end
        EXEC: begin
          state_d = FETCH;
          retire  = 1'b1;
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: begin
              bus.rf_w_en = 1'b1;
              bus.cond_ld = 1'b1;
              bus.alu_op  = (opcode == OP_ADD) ? 2'd0 : (opcode == OP_AND) ? 2'd1 : 2'd2;
            end
            OP_LD, OP_LDR: begin
              bus.mem_addr_sel  = (opcode == OP_LD) ? 2'd1 : 2'd2;
              bus.rf_w_en       = 1'b1;
              bus.rf_w_data_sel = 2'd1;
              bus.cond_ld       = 1'b1;
            end
            OP_ST, OP_STR: begin
              bus.mem_w_en     = 1'b1;
              bus.mem_addr_sel = (opcode == OP_ST) ? 2'd1 : 2'd2;
            end
            OP_LEA: begin
              bus.rf_w_en       = 1'b1;
              bus.rf_w_data_sel = 2'd3;
              bus.cond_ld       = 1'b1;
            end
            OP_BR: begin
              if ((lo_bits & bus.cond) != 3'b000) begin
                bus.pc_ld  = 1'b1;
                bus.pc_sel = 2'd1;
              end
            end
            OP_JSR: begin
              // R7 captures the old PC on the same edge that PC takes the target.
              bus.rf_w_en       = 1'b1;
              bus.rf_w_addr_sel = 1'b1;
              bus.rf_w_data_sel = 2'd2;
              bus.pc_ld         = 1'b1;
              bus.pc_sel        = lo_bits[2] ? 2'd1 : 2'd2;
            end
            OP_JMP: begin
              bus.pc_ld  = 1'b1;
              bus.pc_sel = 2'd2;
            end
            OP_LDI, OP_STI: begin
              bus.tmp_ld       = 1'b1;
              bus.mem_addr_sel = 2'd1;
              state_d          = EXEC2;
              retire           = 1'b0;
            end
            OP_TRAP: state_d = HALT;
            default: ;
          endcase
        end
        EXEC2: begin
          state_d          = FETCH;
          retire           = 1'b1;
          bus.mem_addr_sel = 2'd3;
          if (opcode == OP_LDI) begin
            bus.rf_w_en       = 1'b1;
            bus.rf_w_data_sel = 2'd1;
            bus.cond_ld       = 1'b1;
          end else begin
            bus.mem_w_en = 1'b1;
          end
        end
        HALT: bus.halted = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.instr_count = rst ? count_q : '0;

endmodule
